i2cmb_mbus_master: RTL and testbench

Parametrised byte-level I2C master engine driving `NUM_BUSES` independent open-drain I2C buses through one shared command/response handshake. Next-generation replacement for the fixed-bus byte FSM inside the I2CMB core: bus count and bit rate are generic, with clock stretching and arbitration-loss detection. Sits between the Wishbone register file (command/data/status) and the I2C pads.

---
 rtl/i2cmb_mbus_pkg.sv | 34 +++
 rtl/i2cmb_qtimer.sv | 18 +
 rtl/i2cmb_mbus_master.sv | 182 ++++++++++++++++++
 tb/tb_i2cmb_mbus_master.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/i2cmb_mbus_pkg.sv
// i2cmb_mbus_pkg: shared command, response, state and phase encodings for the multi-bus I2C master
package i2cmb_mbus_pkg;
  localparam int BUS_IDX_W = 4;
  typedef enum logic [2:0] {
    CMD_START    = 3'd0,
    CMD_STOP     = 3'd1,
    CMD_WRITE    = 3'd2,
    CMD_READ_ACK = 3'd3,
    CMD_READ_NAK = 3'd4,
    CMD_SET_BUS  = 3'd5,
    CMD_WAIT     = 3'd6,
    CMD_RSVD     = 3'd7
  } cmd_t;
  typedef enum logic [1:0] {
    RSP_DONE     = 2'd0,
    RSP_NAK      = 2'd1,
    RSP_ARB_LOST = 2'd2,
    RSP_ERROR    = 2'd3
  } rsp_t;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START_S = 3'd1,
    STOP_S  = 3'd2,
    BIT_S   = 3'd3,
    WAIT_S  = 3'd4,
    RESP    = 3'd5
  } state_t;
  typedef enum logic [1:0] {
    PH_A = 2'd0,
    PH_B = 2'd1,
    PH_C = 2'd2,
    PH_D = 2'd3
  } phase_t;
endpackage

// File: rtl/i2cmb_qtimer.sv
// i2cmb_qtimer: quarter-bit down-counter; tick_o marks the last cycle of a phase, hold_i freezes it
module i2cmb_qtimer #(
  parameter int CLK_DIV = 250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic hold_i,
  output logic tick_o
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q;
  assign tick_o = !load_i && !hold_i && cnt_q == '0;
  always_ff @(posedge clk_i) begin
    if (rst_i || load_i || tick_o) cnt_q <= CW'(CLK_DIV - 1);
    else if (!hold_i) cnt_q <= cnt_q - 1'b1;
  end
endmodule

// File: rtl/i2cmb_mbus_master.sv
// i2cmb_mbus_master: byte-level I2C master engine time-sharing one command port over NUM_BUSES buses
module i2cmb_mbus_master
  import i2cmb_mbus_pkg::*;
#(
  parameter int NUM_BUSES = 16,
  parameter int CLK_DIV   = 250
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [2:0]           cmd_i,
  input  logic [7:0]           data_i,
  output logic                 rsp_valid_o,
  output logic [1:0]           rsp_o,
  output logic [7:0]           rdata_o,
  output logic                 busy_o,
  output logic [BUS_IDX_W-1:0] bus_sel_o,
  input  logic [NUM_BUSES-1:0] scl_i,
  input  logic [NUM_BUSES-1:0] sda_i,
  output logic [NUM_BUSES-1:0] scl_o,
  output logic [NUM_BUSES-1:0] sda_o
);
  state_t state_q, state_d;
  phase_t ph_q, ph_d;
  cmd_t cmd_q, cmd_d;
  rsp_t rsp_q, rsp_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] n_q, n_d, sh_q, sh_d, rdata_q, rdata_d;
  logic [BUS_IDX_W-1:0] sel_q, sel_d;
  logic busy_q, busy_d, sda_idle_q, sda_idle_d;
  logic [NUM_BUSES-1:0] scl_sh, sda_sh;
  logic scl_in, sda_in, scl_drv, sda_drv, accept, timed, hold, tick, arb;
  assign scl_sh = scl_i >> sel_q;
  assign sda_sh = sda_i >> sel_q;
  assign scl_in = scl_sh[0];
  assign sda_in = sda_sh[0];
  assign cmd_ready_o = state_q == IDLE || state_q == RESP;
  assign rsp_valid_o = state_q == RESP;
  assign accept = cmd_valid_i && cmd_ready_o;
  assign timed = state_q inside {START_S, STOP_S, BIT_S, WAIT_S};
  // the phase where SCL is first released is the one a slave may stretch
  assign hold = !scl_in && ((state_q == BIT_S && ph_q == PH_C) ||
                            ((state_q == START_S || state_q == STOP_S) && ph_q == PH_B));
  assign arb = tick && !sda_in &&
               ((state_q == START_S && ph_q == PH_C) ||
                (state_q == BIT_S && ph_q == PH_D && !bit_q[3] && cmd_q == CMD_WRITE && sh_q[7]));
  i2cmb_qtimer #(.CLK_DIV(CLK_DIV)) u_qtimer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (!timed),
    .hold_i (hold),
    .tick_o (tick)
  );
  // between commands a captured bus keeps SCL low; SDA rests low only right after START
  always_comb begin
    scl_drv = !busy_q;
    sda_drv = sda_idle_q;
    case (state_q)
      START_S: begin
        scl_drv = !(ph_q == PH_A && busy_q);
        sda_drv = ph_q != PH_D;
      end
      STOP_S: begin
        scl_drv = ph_q != PH_A;
        sda_drv = ph_q == PH_D;
      end
      BIT_S: begin
        scl_drv = ph_q inside {PH_C, PH_D};
        sda_drv = bit_q[3] ? (cmd_q == CMD_WRITE || cmd_q == CMD_READ_NAK)
                           : (cmd_q != CMD_WRITE || sh_q[7]);
      end
      default: ;
    endcase
  end
  assign scl_o = ~(NUM_BUSES'(!scl_drv) << sel_q);
  assign sda_o = ~(NUM_BUSES'(!sda_drv) << sel_q);
  always_comb begin
    state_d = state_q == RESP ? IDLE : state_q;
    ph_d = ph_q;
    cmd_d = cmd_q;
    rsp_d = rsp_q;
    bit_d = bit_q;
    n_d = n_q;
    sh_d = sh_q;
    rdata_d = rdata_q;
    sel_d = sel_q;
    busy_d = busy_q;
    sda_idle_d = sda_idle_q;
    if (accept) begin
      cmd_d = cmd_t'(cmd_i);
      rsp_d = RSP_DONE;
      state_d = RESP;
      ph_d = PH_A;
      bit_d = '0;
      n_d = data_i;
      sh_d = data_i;
      case (cmd_t'(cmd_i))
        CMD_START: state_d = START_S;
        CMD_STOP: begin
          state_d = busy_q ? STOP_S : RESP;
          rsp_d = busy_q ? RSP_DONE : RSP_ERROR;
        end
        CMD_WRITE, CMD_READ_ACK, CMD_READ_NAK: begin
          state_d = busy_q ? BIT_S : RESP;
          rsp_d = busy_q ? RSP_DONE : RSP_ERROR;
        end
        CMD_SET_BUS: begin
          rsp_d = (busy_q || int'(data_i) >= NUM_BUSES) ? RSP_ERROR : RSP_DONE;
          sel_d = rsp_d == RSP_DONE ? data_i[BUS_IDX_W-1:0] : sel_q;
        end
        CMD_WAIT: state_d = data_i != 8'd0 ? WAIT_S : RESP;
        default: rsp_d = RSP_ERROR;
      endcase
    end else if (arb) begin
      state_d = RESP;
      rsp_d = RSP_ARB_LOST;
      busy_d = 1'b0;
      sda_idle_d = 1'b1;
    end else if (tick) begin
      ph_d = phase_t'(ph_q + 2'd1);
      if (ph_q == PH_D) begin
        case (state_q)
          START_S: begin
            state_d = RESP;
            busy_d = 1'b1;
            sda_idle_d = 1'b0;
          end
          STOP_S: begin
            state_d = RESP;
            busy_d = 1'b0;
            sda_idle_d = 1'b1;
          end
          WAIT_S: begin
            n_d = n_q - 8'd1;
            state_d = n_q == 8'd1 ? RESP : WAIT_S;
          end
          BIT_S: begin
            bit_d = bit_q + 4'd1;
            sh_d = bit_q[3] ? sh_q : {sh_q[6:0], sda_in};
            state_d = bit_q[3] ? RESP : BIT_S;
            sda_idle_d = bit_q[3] ? 1'b1 : sda_idle_q;
            rsp_d = (bit_q[3] && cmd_q == CMD_WRITE && sda_in) ? RSP_NAK : RSP_DONE;
            rdata_d = (bit_q[3] && cmd_q != CMD_WRITE) ? sh_q : rdata_q;
          end
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ph_q <= PH_A;
      cmd_q <= CMD_START;
      rsp_q <= RSP_DONE;
      bit_q <= '0;
      n_q <= '0;
      sh_q <= '0;
      rdata_q <= '0;
      sel_q <= '0;
      busy_q <= 1'b0;
      sda_idle_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      cmd_q <= cmd_d;
      rsp_q <= rsp_d;
      bit_q <= bit_d;
      n_q <= n_d;
      sh_q <= sh_d;
      rdata_q <= rdata_d;
      sel_q <= sel_d;
      busy_q <= busy_d;
      sda_idle_q <= sda_idle_d;
    end
  end
  assign rsp_o = rsp_q;
  assign rdata_o = rdata_q;
  assign busy_o = busy_q;
  assign bus_sel_o = sel_q;
endmodule

// File: tb/tb_i2cmb_mbus_master.sv
// tb_i2cmb_mbus_master: directed and randomized command sequences checked against a transaction-level model
module tb_i2cmb_mbus_master;
  localparam int Q = 4;
  localparam int NB = 4;
  localparam logic [1:0] R_DONE = 2'd0, R_NAK = 2'd1, R_ARB = 2'd2, R_ERR = 2'd3;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [2:0] cmd = '0;
  logic [7:0] data = '0;
  logic cmd_ready, rsp_valid, busy;
  logic [1:0] rsp;
  logic [7:0] rdata;
  logic [3:0] bus_sel;
  logic [NB-1:0] scl_o, sda_o, scl_in, sda_in;
  logic stretch = 1'b0, slave_sda = 1'b1, other_sda = 1'b1;
  int checks = 0, fails = 0;
  logic m_busy = 1'b0;
  logic [3:0] m_sel = '0;
  logic [7:0] m_rdata = '0;
  logic ack_val = 1'b0;
  logic [7:0] rd_byte = '0;
  int stretch_at = 0, stretch_cyc = 0, arb_at = -1;
  logic [8:0] seen;
  int stray;
  assign scl_in = scl_o & {NB{!stretch}};
  assign sda_in = sda_o & {NB{slave_sda && other_sda}};
  always #5 clk = ~clk;
  i2cmb_mbus_master #(.NUM_BUSES(NB), .CLK_DIV(Q)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_i(cmd), .data_i(data), .rsp_valid_o(rsp_valid), .rsp_o(rsp), .rdata_o(rdata),
    .busy_o(busy), .bus_sel_o(bus_sel), .scl_i(scl_in), .sda_i(sda_in),
    .scl_o(scl_o), .sda_o(sda_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " ready"}, cmd_ready, 1);
    chk({tag, " rsp_valid"}, rsp_valid, 0);
    chk({tag, " rsp"}, rsp, R_DONE);
    chk({tag, " rdata"}, rdata, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " bus_sel"}, bus_sel, 0);
    chk({tag, " lines"}, {scl_o, sda_o}, 8'hFF);
  endtask
  // issues one command, plays the slave/other-master roles and measures response latency
  task automatic run(input logic [2:0] c, input logic [7:0] d, output int lat);
    logic prev, cur;
    int rises, falls, scnt;
    rises = 0; falls = 0; scnt = 0; seen = '0; stray = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; data = d;
    prev = scl_o[m_sel];
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 2000) begin
      cur = scl_o[m_sel];
      if (cur && !prev) begin
        if (rises < 9) seen[8-rises] = sda_o[m_sel];
        slave_sda = (c == 3'd2) ? (rises == 8 ? ack_val : 1'b1)
                  : ((c == 3'd3 || c == 3'd4) && rises < 8) ? rd_byte[7-rises] : 1'b1;
        rises++;
      end
      if (!cur && prev) begin
        falls++;
        if (falls == stretch_at) stretch = 1'b1;
        if (falls == arb_at) other_sda = 1'b0;
      end
      if (stretch && cur) begin
        if (scnt == stretch_cyc) stretch = 1'b0;
        else scnt++;
      end
      for (int b = 0; b < NB; b++)
        if (b != int'(m_sel) && (scl_o[b] !== 1'b1 || sda_o[b] !== 1'b1)) stray++;
      prev = cur;
      @(negedge clk);
      lat++;
    end
    chk("no_timeout", lat < 2000, 1);
    slave_sda = 1'b1; other_sda = 1'b1; stretch = 1'b0;
  endtask
  // transaction-level expectation: response code and latency in cycles, updates model state
  task automatic predict(input logic [2:0] c, input logic [7:0] d, output logic [1:0] re, output int le);
    int quarters, extra;
    quarters = 0; extra = 0; re = R_DONE;
    case (c)
      3'd0: begin quarters = 4; m_busy = 1'b1; end
      3'd1: if (!m_busy) re = R_ERR; else begin quarters = 4; m_busy = 1'b0; end
      3'd2: if (!m_busy) re = R_ERR;
            else if (arb_at >= 0) begin re = R_ARB; quarters = 4 * (arb_at + 1); m_busy = 1'b0; end
            else begin re = ack_val ? R_NAK : R_DONE; quarters = 36; extra = stretch_cyc; end
      3'd3, 3'd4: if (!m_busy) re = R_ERR; else begin quarters = 36; m_rdata = rd_byte; end
      3'd5: if (m_busy || d >= NB) re = R_ERR; else m_sel = d[3:0];
      3'd6: quarters = 4 * d;
      default: re = R_ERR;
    endcase
    le = 1 + quarters * Q + extra;
  endtask
  task automatic step(input logic [2:0] c, input logic [7:0] d);
    int lat, le;
    logic [1:0] re;
    run(c, d, lat);
    predict(c, d, re, le);
    chk($sformatf("rsp c%0d d%0h", c, d), rsp, re);
    chk($sformatf("lat c%0d d%0h", c, d), lat, le);
    chk($sformatf("ready c%0d", c), cmd_ready, 1);
    chk($sformatf("busy c%0d", c), busy, m_busy);
    chk($sformatf("bus_sel c%0d", c), bus_sel, m_sel);
    chk($sformatf("rdata c%0d", c), rdata, m_rdata);
    chk($sformatf("stray c%0d", c), stray, 0);
    if (c == 3'd2 && re != R_ERR && re != R_ARB) chk($sformatf("wbits d%0h", d), seen, {d, 1'b1});
    if ((c == 3'd3 || c == 3'd4) && re != R_ERR) chk($sformatf("ackbit c%0d", c), seen[0], c == 3'd4);
    if (re == R_ARB) chk("arb_lines", {scl_o, sda_o}, 8'hFF);
  endtask
  initial begin
    logic [2:0] c;
    logic [7:0] d;
    int cnt;
    repeat (3) @(negedge clk);
    chk_reset("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rst_rel");
    step(3'd5, 8'd2);
    step(3'd0, 8'd0);
    step(3'd2, 8'h44);
    step(3'd1, 8'd0);
    step(3'd0, 8'd0);
    ack_val = 1'b1;
    step(3'd2, 8'hA5);
    ack_val = 1'b0;
    step(3'd1, 8'd0);
    step(3'd0, 8'd0);
    rd_byte = 8'h3C;
    step(3'd4, 8'd0);
    step(3'd1, 8'd0);
    step(3'd0, 8'd0);
    stretch_at = 3; stretch_cyc = 10;
    step(3'd2, 8'h5A);
    stretch_at = 0; stretch_cyc = 0;
    step(3'd1, 8'd0);
    step(3'd0, 8'd0);
    arb_at = 1;
    step(3'd2, 8'h40);
    arb_at = -1;
    step(3'd5, 8'd5);
    step(3'd0, 8'd0);
    step(3'd5, 8'd1);
    step(3'd1, 8'd0);
    step(3'd6, 8'd0);
    step(3'd6, 8'd2);
    step(3'd7, 8'd0);
    for (int i = 0; i < 40; i++) begin
      c = 3'($urandom_range(0, 7));
      d = (c == 3'd5) ? 8'($urandom_range(0, 5)) : (c == 3'd6) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      ack_val = 1'($urandom_range(0, 1));
      rd_byte = 8'($urandom);
      step(c, d);
    end
    ack_val = 1'b0;
    if (!m_busy) step(3'd0, 8'd0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'd3; data = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("rst_mid");
    m_busy = 1'b0; m_sel = '0; m_rdata = '0;
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("no_rsp_after_rst", cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
